xor_sop_sweep: RTL
==================

# xor_sop_sweep

Parametrised XOR-of-products function engine, the sequential successor to the fixed 4-input P-function circuit. It holds a programmable set of product terms whose outputs are XORed into P. It runs in two modes: a single-vector evaluation with a registered result, or an autonomous sweep over all 2^N_IN input vectors. A sweep streams each result and builds the full truth-table bitmap and ones count, so a function can be checked in hardware with no bench-side enumeration.

## Interface
- N_IN, 4, number of function inputs (1..8); vector bit N_IN-1 is the leftmost variable (W), bit 0 the rightmost (Z)
- N_TERM, 3, number of product terms (1..8)
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_care  in  N_TERM*N_IN  term t literal i at bit t*N_IN+i; 1 = literal participates
- cfg_pol  in  N_TERM*N_IN  same layout; 1 = true literal, 0 = complemented
- cfg_load  in  1  capture cfg_care/cfg_pol (IDLE only)
- start  in  1  begin sweep (IDLE only)
- eval_req  in  1  evaluate vec_in once (IDLE only)
- vec_in  in  N_IN  vector for eval_req
- busy  out  1  high in SWEEP and DONE
- p_valid  out  1  p_vec/p_out valid this cycle
- p_vec  out  N_IN  vector that produced p_out
- p_out  out  1  function value
- done  out  1  one-cycle pulse at sweep end
- table_out  out  2^N_IN  bit k = P(k), from the last completed or in-progress sweep
- ones_cnt  out  N_IN+1  number of vectors with P=1

## Operation
- Term t = AND over i with care[t][i]=1 of (x_i == pol[t][i]). A term with no care bits evaluates to 1. P = XOR of all N_TERM terms.
- The function always uses the captured config registers. The cfg_* inputs are sampled only when cfg_load is high and the FSM is in IDLE; cfg_load is ignored otherwise.
- FSM states are IDLE, SWEEP and DONE.
- IDLE with start=1: go to SWEEP, set idx<=0, clear table_out and ones_cnt.
- IDLE with eval_req=1 and start=0: on the next edge set p_valid<=1, p_vec<=vec_in, p_out<=P(vec_in). The FSM stays in IDLE; table_out and ones_cnt are unchanged.
- start has priority; an eval_req in the same cycle is dropped. cfg_load in the same cycle as start is applied first, so the sweep uses the new config.
- SWEEP, every edge:
  - p_valid<=1, p_vec<=idx, p_out<=P(idx)
  - table_out[idx]<=P(idx), ones_cnt<=ones_cnt+P(idx)
  - idx<=idx+1
  - When idx==2^N_IN-1, go to DONE. Termination is by compare, not by counter wrap.
- DONE: for one cycle done=1 and busy=1, with the last p_valid visible in that same cycle; then return to IDLE.
- start, eval_req and cfg_load are ignored while busy.
- Reset values: state IDLE; busy, p_valid, p_vec, p_out, done, table_out, ones_cnt and the config registers all 0.
  - With all-zero care, P = N_TERM mod 2.
- rst mid-sweep aborts immediately: outputs return to reset values and done is not pulsed.

## Timing
- Eval latency is 1 cycle: eval_req is sampled at edge E, and the result is visible after E.
- Sweep: start is sampled at edge S; the result for vector k is visible after edge S+1+k.
- busy is high for 2^N_IN+1 cycles.
- done coincides with the p_valid for vector 2^N_IN-1.
- p_valid is otherwise 0. p_vec and p_out hold their last values when p_valid=0.
- Back-to-back: a start in the cycle after done is accepted.

## Structure
- Package xor_sop_pkg holds:
  - the state enum (IDLE/SWEEP/DONE)
  - the parameter range checks
  - the cfg bit-index helper t*N_IN+i
- Sub-module xor_sop_eval: purely combinational N_IN-input evaluator with inputs care, pol and vec and output p.
  - Instantiated once, with vec = busy ? idx : vec_in.
- Top level holds the FSM, idx counter, config registers, table/count accumulation and output registers.

## Test plan
Default parameters; reference config care=12'h63B, pol=12'h239 encodes P = W·Y'·Z ^ Y·Z ^ X'·Y.
- Reset, then start with no cfg_load -> 16 p_valid cycles all with p_out=1; table_out=16'hFFFF; ones_cnt=16; done once.
- Load the reference config, start -> p_vec runs 0..15 on consecutive cycles; busy high 17 cycles; done with p_vec=15; table_out=16'hA684; ones_cnt=6.
- Reference config in IDLE: eval_req with vec_in=4'h9 -> next cycle p_valid=1, p_out=1; eval_req with vec_in=4'h3 -> p_out=0; table_out and ones_cnt unchanged.
- During a sweep, pulse start, eval_req and cfg_load with care=0 -> all ignored; the sweep result is still 16'hA684 and the next sweep reproduces it.
- Assert rst in the cycle p_vec=7 -> next cycle busy=0, table_out=0, ones_cnt=0, and done never pulses.
- start, eval_req and cfg_load (reference config) in the same IDLE cycle -> sweep runs on the new config, the eval is dropped, and the result is 16'hA684.

Source files
------------

// File: rtl/xor_sop_sweep_pkg.sv
// Shared types, parameter limits and config indexing for the XOR-of-products sweep engine.
package xor_sop_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int unsigned N_IN_MIN   = 1;
    localparam int unsigned N_IN_MAX   = 8;
    localparam int unsigned N_TERM_MIN = 1;
    localparam int unsigned N_TERM_MAX = 8;

    function automatic bit params_ok(input int unsigned n_in, input int unsigned n_term);
        return (n_in >= N_IN_MIN) && (n_in <= N_IN_MAX) &&
               (n_term >= N_TERM_MIN) && (n_term <= N_TERM_MAX);
    endfunction

    // Flat position of literal i of term t in cfg_care/cfg_pol.
    function automatic int unsigned cfg_idx(input int unsigned t, input int unsigned i,
                                            input int unsigned n_in);
        return t * n_in + i;
    endfunction

endpackage

// File: rtl/xor_sop_sweep_if.sv
// Config, command and result bundle of the sweep engine.
interface xor_sop_sweep_if #(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned N_TERM = 3
);
    localparam int unsigned CFG_W = N_TERM * N_IN;
    localparam int unsigned TBL_W = 1 << N_IN;

    logic [CFG_W-1:0] cfg_care;
    logic [CFG_W-1:0] cfg_pol;
    logic             cfg_load;
    logic             start;
    logic             eval_req;
    logic [N_IN-1:0]  vec_in;
    logic             busy;
    logic             p_valid;
    logic [N_IN-1:0]  p_vec;
    logic             p_out;
    logic             done;
    logic [TBL_W-1:0] table_out;
    logic [N_IN:0]    ones_cnt;

    modport master (
        output cfg_care, cfg_pol, cfg_load, start, eval_req, vec_in,
        input  busy, p_valid, p_vec, p_out, done, table_out, ones_cnt
    );

    modport slave (
        input  cfg_care, cfg_pol, cfg_load, start, eval_req, vec_in,
        output busy, p_valid, p_vec, p_out, done, table_out, ones_cnt
    );
endinterface

// File: rtl/xor_sop_eval.sv
// Combinational XOR-of-products evaluator; an empty term contributes a constant 1.
module xor_sop_eval
    import xor_sop_pkg::*;
#(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned N_TERM = 3
) (
    input  logic [N_TERM*N_IN-1:0] care,
    input  logic [N_TERM*N_IN-1:0] pol,
    input  logic [N_IN-1:0]        vec,
    output logic                   p
);
    logic term;

    always_comb begin
        p    = 1'b0;
        term = 1'b1;
        for (int unsigned t = 0; t < N_TERM; t++) begin
            term = 1'b1;
            for (int unsigned i = 0; i < N_IN; i++) begin
                if (care[cfg_idx(t, i, N_IN)] && (vec[i] != pol[cfg_idx(t, i, N_IN)]))
                    term = 1'b0;
            end
            p = p ^ term;
        end
    end
endmodule

// File: rtl/xor_sop_sweep.sv
// Sweep engine top: FSM, config capture, index counter and registered results.
module xor_sop_sweep
    import xor_sop_pkg::*;
#(
    parameter int unsigned N_IN   = 4,
    parameter int unsigned N_TERM = 3
) (
    input  logic           clk,
    input  logic           rst,
    xor_sop_sweep_if.slave bus
);
    localparam int unsigned CFG_W = N_TERM * N_IN;
    localparam int unsigned TBL_W = 1 << N_IN;
    localparam logic [N_IN-1:0] IDX_LAST = '1;

    if (!params_ok(N_IN, N_TERM)) begin : g_bad_params
        $error("xor_sop_sweep: N_IN and N_TERM must each be in 1..8");
    end

    state_e           state_q, state_d;
    logic [N_IN-1:0]  idx_q;
    logic [CFG_W-1:0] care_q, pol_q;
    logic             busy_q, done_q, p_valid_q, p_out_q;
    logic [N_IN-1:0]  p_vec_q;
    logic [TBL_W-1:0] table_q;
    logic [N_IN:0]    ones_q;
    logic [N_IN-1:0]  eval_vec;
    logic             p_c;
    logic             load_cfg_c, start_c, eval_c, step_c, last_c;

    assign eval_vec = busy_q ? idx_q : bus.vec_in;

    xor_sop_eval #(.N_IN(N_IN), .N_TERM(N_TERM)) u_eval (
        .care (care_q),
        .pol  (pol_q),
        .vec  (eval_vec),
        .p    (p_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = SWEEP;
            SWEEP:   if (idx_q == IDX_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Command strobes: everything except the sweep step is honoured only in IDLE.
    always_comb begin
        load_cfg_c = (state_q == IDLE) && bus.cfg_load;
        start_c    = (state_q == IDLE) && bus.start;
        eval_c     = (state_q == IDLE) && bus.eval_req && !bus.start;
        step_c     = (state_q == SWEEP);
        last_c     = step_c && (idx_q == IDX_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            care_q    <= '0;
            pol_q     <= '0;
            idx_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            p_valid_q <= 1'b0;
            p_vec_q   <= '0;
            p_out_q   <= 1'b0;
            table_q   <= '0;
            ones_q    <= '0;
        end else begin
            if (load_cfg_c) begin
                care_q <= bus.cfg_care;
                pol_q  <= bus.cfg_pol;
            end
            busy_q    <= (state_d != IDLE);
            done_q    <= last_c;
            p_valid_q <= step_c || eval_c;
            if (start_c) begin
                idx_q   <= '0;
                table_q <= '0;
                ones_q  <= '0;
            end else if (step_c) begin
                idx_q          <= idx_q + N_IN'(1);
                table_q[idx_q] <= p_c;
                ones_q         <= ones_q + (N_IN + 1)'(p_c);
                p_vec_q        <= idx_q;
                p_out_q        <= p_c;
            end else if (eval_c) begin
                p_vec_q <= bus.vec_in;
                p_out_q <= p_c;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.p_valid   = p_valid_q;
    assign bus.p_vec     = p_vec_q;
    assign bus.p_out     = p_out_q;
    assign bus.table_out = table_q;
    assign bus.ones_cnt  = ones_q;
endmodule
